// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions,
// bias and canonical quiet-NaN helpers for any exponent/fraction width.
package fp_pkg;

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_cls_e;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical qNaN right-aligned in 64 bits: sign 0, exp all ones, frac MSB 1.
   function automatic logic [63:0] qnan(input int exp_w, input int man_w);
      logic [63:0] exp_ones;
      exp_ones = (64'd1 << exp_w) - 64'd1;
      return (exp_ones << man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final multiplier stage: normalise the raw significand product, round to
// nearest-even, then resolve special operands and exponent range into a
// packed result and exception flags. Purely combinational.
module fp_mul_round import fp_pkg::*; #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W    = 1 + EXP_W + MAN_W,
   localparam int PW   = 2 * MAN_W + 2
) (
   input  logic                    sign,
   input  fp_cls_e                 cls_a,
   input  fp_cls_e                 cls_b,
   input  logic                    snan,
   input  logic signed [EXP_W+1:0] exp_sum,
   input  logic [PW-1:0]           prod,
   output logic [W-1:0]            res,
   output logic [3:0]              flg
);

   // One extra exponent bit so the +1 carries never wrap the sign.
   localparam int EW = EXP_W + 3;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [63:0] QNAN = qnan(EXP_W, MAN_W);

   logic [PW-2:0]          norm;
   logic [MAN_W-1:0]       frac_t;
   logic                   g, r, s, up, inexact;
   logic [MAN_W:0]         frac_r;
   logic signed [EW-1:0]   exp_f;
   logic                   any_nan, inf_zero, any_inf, any_zero;

   // Normalise, round and pick the result by special-case priority.
   always_comb begin
      // Hidden bit of the product is dropped here: it is 1 for normal operands.
      norm    = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      frac_t  = norm[PW-2:MAN_W+1];
      g       = norm[MAN_W];
      r       = norm[MAN_W-1];
      s       = |norm[MAN_W-2:0];
      up      = g & (r | s | frac_t[0]);
      inexact = g | r | s;
      // Carry out of the fraction means 1.111..1 rounded up to 10.000..0:
      // the fraction bits are already zero, only the exponent moves.
      frac_r  = {1'b0, frac_t} + (MAN_W+1)'(up);
      exp_f   = EW'(exp_sum) + EW'(prod[PW-1]) + EW'(frac_r[MAN_W]);

      any_nan  = (cls_a == CLS_NAN) || (cls_b == CLS_NAN);
      inf_zero = ((cls_a == CLS_INF) && (cls_b == CLS_ZERO)) ||
                 ((cls_a == CLS_ZERO) && (cls_b == CLS_INF));
      any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
      any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);

      res = '0;
      flg = '0;
      if (any_nan || inf_zero) begin
         res          = QNAN[W-1:0];
         flg[FLG_INV] = inf_zero | snan;
      end else if (any_inf) begin
         res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (any_zero) begin
         res = {sign, {(W-1){1'b0}}};
      end else if (exp_f >= EXP_MAX) begin
         res          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg[FLG_OVF] = 1'b1;
         flg[FLG_INX] = 1'b1;
      end else if (exp_f[EW-1] || (exp_f == '0)) begin
         res          = {sign, {(W-1){1'b0}}};
         flg[FLG_UNF] = 1'b1;
         flg[FLG_INX] = 1'b1;
      end else begin
         res          = {sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
         flg[FLG_INX] = inexact;
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control.
// S1 unpacks/classifies, S2 multiplies significands, S3 registers the
// rounded, packed result. The whole pipe stalls when the output is held.
module fp_mul_pipe import fp_pkg::*; #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int STAGES = 3;
   localparam int PW     = 2 * MAN_W + 2;
   localparam int EW     = EXP_W + 2;

   logic              en;
   logic [STAGES:1]   vld_pipe;

   assign en        = !vld_pipe[STAGES] || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES];

   function automatic fp_cls_e cls_of(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return CLS_ZERO;
      if (&e)      return (f == '0) ? CLS_INF : CLS_NAN;
      return CLS_NORM;
   endfunction

   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  fa, fb;
   fp_cls_e           ca_d, cb_d;
   logic              snan_d;
   logic [EW-1:0]     exp_d;

   // S1 unpack: classify operands and form the biased exponent sum.
   always_comb begin
      ea     = a[W-2:MAN_W];
      eb     = b[W-2:MAN_W];
      fa     = a[MAN_W-1:0];
      fb     = b[MAN_W-1:0];
      ca_d   = cls_of(ea, fa);
      cb_d   = cls_of(eb, fb);
      snan_d = ((ca_d == CLS_NAN) && !fa[MAN_W-1]) || ((cb_d == CLS_NAN) && !fb[MAN_W-1]);
      exp_d  = EW'(ea) + EW'(eb) - EW'(bias(EXP_W));
   end

   logic                 s1_sign, s1_snan;
   fp_cls_e              s1_cls_a, s1_cls_b;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]       s1_ma, s1_mb;

   logic                 s2_sign, s2_snan;
   fp_cls_e              s2_cls_a, s2_cls_b;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;

   logic [W-1:0]         res_d;
   logic [3:0]           flg_d;

   fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .sign    (s2_sign),
      .cls_a   (s2_cls_a),
      .cls_b   (s2_cls_b),
      .snan    (s2_snan),
      .exp_sum (s2_exp),
      .prod    (s2_prod),
      .res     (res_d),
      .flg     (flg_d)
   );

   // Valid shift register; advances only with the shared enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
   end

   // Datapath registers for all three stages, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sign  <= 1'b0;
         s1_snan  <= 1'b0;
         s1_cls_a <= CLS_ZERO;
         s1_cls_b <= CLS_ZERO;
         s1_exp   <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s2_sign  <= 1'b0;
         s2_snan  <= 1'b0;
         s2_cls_a <= CLS_ZERO;
         s2_cls_b <= CLS_ZERO;
         s2_exp   <= '0;
         s2_prod  <= '0;
         result   <= '0;
         flags    <= '0;
      end else if (en) begin
         s1_sign  <= a[W-1] ^ b[W-1];
         s1_snan  <= snan_d;
         s1_cls_a <= ca_d;
         s1_cls_b <= cb_d;
         s1_exp   <= exp_d;
         s1_ma    <= {1'b1, fa};
         s1_mb    <= {1'b1, fb};
         s2_sign  <= s1_sign;
         s2_snan  <= s1_snan;
         s2_cls_a <= s1_cls_a;
         s2_cls_b <= s1_cls_b;
         s2_exp   <= s1_exp;
         s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
         result   <= res_d;
         flags    <= flg_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single precision instance plus a
// half-precision instance, hand-computed expected products.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_result;
   logic [3:0]  h_flags;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_mul_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result), .flags(h_flags)
   );

   // Drive one operand pair into an empty pipe, return result and latency.
   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] res, output logic [3:0] flg, output int lat);
      @(negedge clk);
      a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      res = result; flg = flags;
   endtask

   task automatic run_op_h(input logic [15:0] xa, input logic [15:0] xb,
                           output logic [15:0] res, output logic [3:0] flg, output int lat);
      @(negedge clk);
      h_a = xa; h_b = xb; h_in_valid = 1'b1; h_out_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      h_in_valid = 1'b0;
      while (!h_out_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      res = h_result; flg = h_flags;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0;
      #12;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h expected 00000000", result); end
      n_tests++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset flags: got %b expected 0000", flags); end
      n_tests++; if (h_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset h_out_valid: got %b expected 0", h_out_valid); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [31:0] res; logic [3:0] flg; int lat;
      run_op(32'h40000000, 32'h40400000, res, flg, lat);
      n_tests++; if (res !== 32'h40C00000) begin n_fail++; $display("FAIL basic result: got %h expected 40c00000", res); end
      n_tests++; if (flg !== 4'b0000) begin n_fail++; $display("FAIL basic flags: got %b expected 0000", flg); end
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL basic latency: got %0d expected 3", lat); end
   endtask

   // Rounding, range boundaries and signed zero.
   task automatic test_arith();
      logic [31:0] va [0:10], vb [0:10], ve [0:10];
      logic [3:0]  vf [0:10];
      logic [31:0] res; logic [3:0] flg; int lat;
      va = '{32'h3F800001, 32'h3FC00000, 32'h3F800001, 32'h3F800003, 32'h7F000000, 32'h7F000000,
             32'h7E800000, 32'h00800000, 32'h00800000, 32'h00800000, 32'h80000000};
      vb = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h7F000000, 32'h40000000,
             32'h40000000, 32'h00800000, 32'h3F800000, 32'h3F000000, 32'h3F800000};
      ve = '{32'h3F800002, 32'h40100000, 32'h3FC00002, 32'h3FC00004, 32'h7F800000, 32'h7F800000,
             32'h7F000000, 32'h00000000, 32'h00800000, 32'h00000000, 32'h80000000};
      vf = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101,
             4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
      for (int i = 0; i < 11; i++) begin
         run_op(va[i], vb[i], res, flg, lat);
         n_tests++; if (res !== ve[i]) begin n_fail++; $display("FAIL arith[%0d] result: got %h expected %h", i, res, ve[i]); end
         n_tests++; if (flg !== vf[i]) begin n_fail++; $display("FAIL arith[%0d] flags: got %b expected %b", i, flg, vf[i]); end
      end
   endtask

   task automatic test_special();
      logic [31:0] va [0:6], vb [0:6], ve [0:6];
      logic [3:0]  vf [0:6];
      logic [31:0] res; logic [3:0] flg; int lat;
      va = '{32'h7F800000, 32'h7FC00000, 32'h7F800001, 32'hFF800000, 32'hFF800000, 32'h00000000, 32'h00000001};
      vb = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h80000000, 32'h3F800000};
      ve = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'h80000000, 32'h00000000};
      vf = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], res, flg, lat);
         n_tests++; if (res !== ve[i]) begin n_fail++; $display("FAIL special[%0d] result: got %h expected %h", i, res, ve[i]); end
         n_tests++; if (flg !== vf[i]) begin n_fail++; $display("FAIL special[%0d] flags: got %b expected %b", i, flg, vf[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ta [0:9], tb2 [0:9], te [0:9];
      logic [15:0] pat;
      logic [31:0] res_prev; logic [3:0] flg_prev;
      logic        stall_prev, acc;
      int ia, io, cyc;
      ta  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000,
              32'h40A00000, 32'h40400000, 32'h40A00000, 32'h3FC00000, 32'hC0000000};
      tb2 = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40800000, 32'h40800000,
              32'h40000000, 32'h40800000, 32'h40A00000, 32'h3FC00000, 32'h40400000};
      te  = '{32'h40000000, 32'h40C00000, 32'h41100000, 32'h41000000, 32'h41800000,
              32'h41200000, 32'h41400000, 32'h41C80000, 32'h40100000, 32'hC0C00000};
      pat = 16'b1011_0010_1110_0101;
      ia = 0; io = 0; cyc = 0; stall_prev = 1'b0; res_prev = '0; flg_prev = '0;
      while (io < 10 && cyc < 300) begin
         @(negedge clk);
         if (stall_prev) begin
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b hold valid cyc %0d: got %b expected 1", cyc, out_valid); end
            n_tests++; if (result !== res_prev || flags !== flg_prev) begin n_fail++;
               $display("FAIL b2b hold data cyc %0d: got %h/%b expected %h/%b", cyc, result, flags, res_prev, flg_prev); end
         end
         out_ready = pat[cyc % 16];
         in_valid  = (ia < 10);
         a = (ia < 10) ? ta[ia] : 32'h0;
         b = (ia < 10) ? tb2[ia] : 32'h0;
         #1;
         n_tests++; if (in_ready !== (!out_valid || out_ready)) begin n_fail++;
            $display("FAIL b2b in_ready cyc %0d: got %b expected %b", cyc, in_ready, !out_valid || out_ready); end
         if (out_valid && out_ready) begin
            n_tests++; if (result !== te[io] || flags !== 4'b0000) begin n_fail++;
               $display("FAIL b2b result[%0d]: got %h/%b expected %h/0000", io, result, flags, te[io]); end
            io++;
         end
         stall_prev = out_valid && !out_ready;
         res_prev = result; flg_prev = flags;
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) ia++;
         cyc++;
      end
      n_tests++; if (io !== 10) begin n_fail++; $display("FAIL b2b count: got %0d expected 10", io); end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b extra output cyc %0d: got %b expected 0", k, out_valid); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; logic [3:0] flg; int lat;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; a = 32'h40000000; b = 32'h40400000;
         @(posedge clk);
      end
      @(negedge clk); in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid filled: got %b expected 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid out_valid: got %b expected 0", out_valid); end
      n_tests++; if (result !== 32'h0 || flags !== 4'h0) begin n_fail++; $display("FAIL rstmid data: got %h/%b expected 0/0", result, flags); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale cyc %0d: got %b expected 0", k, out_valid); end
      end
      run_op(32'h40000000, 32'h40400000, res, flg, lat);
      n_tests++; if (res !== 32'h40C00000 || lat !== 3) begin n_fail++;
         $display("FAIL rstmid recover: got %h lat %0d expected 40c00000 lat 3", res, lat); end
   endtask

   task automatic test_half();
      logic [15:0] res; logic [3:0] flg; int lat;
      run_op_h(16'h4000, 16'h4200, res, flg, lat);
      n_tests++; if (res !== 16'h4600) begin n_fail++; $display("FAIL half mul result: got %h expected 4600", res); end
      n_tests++; if (flg !== 4'b0000) begin n_fail++; $display("FAIL half mul flags: got %b expected 0000", flg); end
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL half latency: got %0d expected 3", lat); end
      run_op_h(16'h7BFF, 16'h4000, res, flg, lat);
      n_tests++; if (res !== 16'h7C00) begin n_fail++; $display("FAIL half ovf result: got %h expected 7c00", res); end
      n_tests++; if (flg !== 4'b0101) begin n_fail++; $display("FAIL half ovf flags: got %b expected 0101", flg); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_special();
      test_back_to_back();
      test_reset_mid();
      test_half();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
